// File: rtl/okand_pkg.sv
`default_nettype none
// ============================================================================
// Module   : okand_pkg
// Brief    : Shared defaults and FSM state type for the okand serial host.
// Revision : 1.0 - initial release
// ============================================================================
package okand_pkg;

   localparam int c_op_w_default    = 16;
   localparam int c_timeout_default = 64;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEND  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RECV  = 3'd3,
      ST_DONE  = 3'd4,
      ST_ABORT = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/okand_if.sv
`default_nettype none
// ============================================================================
// Module   : okand_if
// Brief    : Request/response handshake bundle between a client and the host.
// Revision : 1.0 - initial release
// ============================================================================
interface okand_if
   import okand_pkg::*;
#(
   parameter int OP_W = c_op_w_default
);

   logic            req_valid;
   logic            req_ready;
   logic [OP_W-1:0] op_a;
   logic [OP_W-1:0] op_b;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [OP_W-1:0] rsp_result;
   logic            rsp_error;

   modport master (
      output req_valid, op_a, op_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_error
   );

   modport slave (
      input  req_valid, op_a, op_b, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_error
   );

endinterface
`default_nettype wire

// File: rtl/okand_timeout.sv
`default_nettype none
// ============================================================================
// Module   : okand_timeout
// Brief    : Idle-cycle counter; expire fires on the TIMEOUT-th consecutive tick.
// Revision : 1.0 - initial release
// ============================================================================
module okand_timeout
   import okand_pkg::*;
#(
   parameter int TIMEOUT = c_timeout_default
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_tick,
   output logic o_expire
);

   localparam int c_cnt_w = $clog2(TIMEOUT + 1);

   logic [c_cnt_w-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_tick) begin
         r_cnt <= r_cnt + c_cnt_w'(1);
      end
   end

   assign o_expire = i_tick && (r_cnt == c_cnt_w'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/okand_host.sv
`default_nettype none
// ============================================================================
// Module   : okand_host
// Brief    : Serialises two operands to a responder and collects its serial result.
// Revision : 1.0 - initial release
// ============================================================================
module okand_host
   import okand_pkg::*;
#(
   parameter int OP_W    = c_op_w_default,
   parameter int TIMEOUT = c_timeout_default
) (
   input  logic     pc_clk,
   input  logic     pc_rst,
   okand_if.slave   bus,
   input  logic     tx_stall,
   output logic     pc_data,
   output logic     pc_valid,
   output logic     link_rst,
   input  logic     fpga_data,
   input  logic     fpga_valid
);

   localparam int c_sh_w = 2 * OP_W;
   localparam int c_tx_w = $clog2(c_sh_w);
   localparam int c_rx_w = (OP_W > 1) ? $clog2(OP_W) : 1;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_sh_w-1:0]   r_shift;
   logic [c_tx_w-1:0]   r_tx_idx;
   logic [c_rx_w-1:0]   r_rx_idx;
   logic [OP_W-1:0]     r_result;
   logic                r_error;
   logic                r_pc_data;
   logic                r_pc_valid;
   logic                r_link_rst;
   logic                r_abort_cnt;

   logic w_accept, w_tx_fire, w_tx_last, w_rx_listen, w_rx_fire, w_rx_last;
   logic w_to_expire;

   assign w_accept    = bus.req_valid && (r_state == ST_IDLE);
   assign w_tx_fire   = (r_state == ST_SEND) && !tx_stall;
   assign w_tx_last   = w_tx_fire && (r_tx_idx == c_tx_w'(c_sh_w - 1));
   assign w_rx_listen = (r_state == ST_WAIT) || (r_state == ST_RECV);
   assign w_rx_fire   = w_rx_listen && fpga_valid;
   assign w_rx_last   = w_rx_fire && (r_rx_idx == c_rx_w'(OP_W - 1));

   // Cleared as WAIT is entered and on every captured bit; counts only idle listening cycles.
   okand_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (pc_clk),
      .rst      (pc_rst),
      .i_clear  (w_tx_last || w_rx_fire),
      .i_tick   (w_rx_listen && !fpga_valid),
      .o_expire (w_to_expire)
   );

   always_ff @(posedge pc_clk or posedge pc_rst) begin
      if (pc_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:  if (w_accept) w_state_nxt = ST_SEND;
         ST_SEND:  if (w_tx_last) w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (w_rx_last)        w_state_nxt = ST_DONE;
            else if (w_rx_fire)   w_state_nxt = ST_RECV;
            else if (w_to_expire) w_state_nxt = ST_ABORT;
         end
         ST_RECV: begin
            if (w_rx_last)        w_state_nxt = ST_DONE;
            else if (w_to_expire) w_state_nxt = ST_ABORT;
         end
         ST_ABORT: if (r_abort_cnt) w_state_nxt = ST_DONE;
         ST_DONE:  if (bus.rsp_ready) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge pc_clk or posedge pc_rst) begin
      if (pc_rst) begin
         r_shift     <= '0;
         r_tx_idx    <= '0;
         r_rx_idx    <= '0;
         r_result    <= '0;
         r_error     <= 1'b0;
         r_pc_data   <= 1'b0;
         r_pc_valid  <= 1'b0;
         r_link_rst  <= 1'b1;
         r_abort_cnt <= 1'b0;
      end else begin
         // Registered so the responder reset spans exactly the ABORT residency.
         r_link_rst <= (w_state_nxt == ST_ABORT);
         r_pc_valid <= w_tx_fire;
         if (w_accept) begin
            r_shift  <= {bus.op_b, bus.op_a};
            r_tx_idx <= '0;
            r_rx_idx <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
         end
         if (w_tx_fire) begin
            r_pc_data <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_tx_idx  <= r_tx_idx + c_tx_w'(1);
         end
         if (w_rx_fire) begin
            r_result[r_rx_idx] <= fpga_data;
            r_rx_idx           <= r_rx_idx + c_rx_w'(1);
         end
         if (r_state == ST_ABORT) begin
            r_abort_cnt <= ~r_abort_cnt;
            r_result    <= '0;
            r_error     <= 1'b1;
         end
      end
   end

   assign pc_data        = r_pc_data;
   assign pc_valid       = r_pc_valid;
   assign link_rst       = r_link_rst;
   assign bus.req_ready  = (r_state == ST_IDLE);
   assign bus.rsp_valid  = (r_state == ST_DONE);
   assign bus.rsp_result = r_result;
   assign bus.rsp_error  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_okand_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_okand_host
// Brief    : Directed bench for okand_host with an AND-computing serial responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_okand_host;
   import okand_pkg::*;

   localparam int OP_W    = c_op_w_default;
   localparam int TIMEOUT = 64;

   logic pc_clk     = 1'b0;
   logic pc_rst     = 1'b1;
   logic tx_stall   = 1'b0;
   logic fpga_data  = 1'b0;
   logic fpga_valid = 1'b0;
   logic pc_data, pc_valid, link_rst;

   int n_checks = 0;
   int n_errors = 0;

   okand_if #(.OP_W(OP_W)) bus ();

   okand_host #(
      .OP_W    (OP_W),
      .TIMEOUT (TIMEOUT)
   ) u_dut (
      .pc_clk     (pc_clk),
      .pc_rst     (pc_rst),
      .bus        (bus),
      .tx_stall   (tx_stall),
      .pc_data    (pc_data),
      .pc_valid   (pc_valid),
      .link_rst   (link_rst),
      .fpga_data  (fpga_data),
      .fpga_valid (fpga_valid)
   );

   always #5 pc_clk = ~pc_clk;

   // ---------------- stimulus helpers ----------------
   task automatic issue(input logic [15:0] a, input logic [15:0] b);
      @(negedge pc_clk);
      bus.req_valid = 1'b1;
      bus.op_a      = a;
      bus.op_b      = b;
      @(negedge pc_clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic collect(input int stall_at, input int stall_len, input bit noise,
                          output logic [31:0] bits, output int pulses, output int span,
                          output logic pv_after);
      int  cyc = 0, first = -1, last = -1, left = 0;
      bit  stalled = 1'b0;
      bits   = '0;
      pulses = 0;
      while (pulses < 32 && cyc < 200) begin
         @(negedge pc_clk);
         cyc++;
         if (pc_valid === 1'b1) begin
            bits[pulses] = pc_data;
            pulses++;
            if (first < 0) first = cyc;
            last = cyc;
         end
         if (!stalled && pulses == stall_at) begin
            left    = stall_len;
            stalled = 1'b1;
         end
         tx_stall = (left > 0);
         if (left > 0) left--;
         fpga_valid = noise && (pulses < 32);
         fpga_data  = noise;
      end
      tx_stall   = 1'b0;
      fpga_valid = 1'b0;
      fpga_data  = 1'b0;
      span = last - first + 1;
      @(negedge pc_clk);
      pv_after = pc_valid;
   endtask

   task automatic respond(input logic [15:0] r, input int gap_after, input int gap_len);
      for (int i = 0; i < 16; i++) begin
         @(negedge pc_clk);
         fpga_valid = 1'b1;
         fpga_data  = r[i];
         if (i == gap_after) begin
            for (int g = 0; g < gap_len; g++) begin
               @(negedge pc_clk);
               fpga_valid = 1'b0;
               fpga_data  = 1'b0;
            end
         end
      end
      @(negedge pc_clk);
      fpga_valid = 1'b0;
      fpga_data  = 1'b0;
   endtask

   task automatic release_rsp();
      bus.rsp_ready = 1'b1;
      @(negedge pc_clk);
      bus.rsp_ready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge pc_clk);
      @(negedge pc_clk);
      n_checks++; if (pc_valid !== 1'b0) begin n_errors++; $display("FAIL reset_pc_valid: got %b expected 0", pc_valid); end
      n_checks++; if (link_rst !== 1'b1) begin n_errors++; $display("FAIL reset_link_rst: got %b expected 1", link_rst); end
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
      n_checks++; if (bus.rsp_result !== 16'h0) begin n_errors++; $display("FAIL reset_rsp_result: got %h expected 0000", bus.rsp_result); end
      n_checks++; if (bus.rsp_error !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_error: got %b expected 0", bus.rsp_error); end
      pc_rst = 1'b0;
      #1;
      n_checks++; if (link_rst !== 1'b1) begin n_errors++; $display("FAIL reset_link_hold: got %b expected 1", link_rst); end
      @(negedge pc_clk);
      n_checks++; if (link_rst !== 1'b0) begin n_errors++; $display("FAIL reset_link_release: got %b expected 0", link_rst); end
      n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
   endtask

   task automatic test_basic();
      logic [31:0] bits; int pulses, span; logic pv;
      issue(16'hFFFF, 16'h0F0F);
      collect(-1, 0, 1'b1, bits, pulses, span, pv);
      n_checks++; if (pulses !== 32) begin n_errors++; $display("FAIL basic_pulses: got %0d expected 32", pulses); end
      n_checks++; if (bits !== 32'h0F0F_FFFF) begin n_errors++; $display("FAIL basic_bits: got %h expected 0f0fffff", bits); end
      n_checks++; if (span !== 32) begin n_errors++; $display("FAIL basic_span: got %0d expected 32", span); end
      n_checks++; if (pv !== 1'b0) begin n_errors++; $display("FAIL basic_valid_after: got %b expected 0", pv); end
      respond(bits[15:0] & bits[31:16], -1, 0);
      n_checks++; if (bus.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL basic_rsp_valid: got %b expected 1", bus.rsp_valid); end
      n_checks++; if (bus.req_ready !== 1'b0) begin n_errors++; $display("FAIL basic_req_ready: got %b expected 0", bus.req_ready); end
      n_checks++; if (bus.rsp_result !== 16'h0F0F) begin n_errors++; $display("FAIL basic_result: got %h expected 0f0f", bus.rsp_result); end
      n_checks++; if (bus.rsp_error !== 1'b0) begin n_errors++; $display("FAIL basic_error: got %b expected 0", bus.rsp_error); end
      release_rsp();
      n_checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL basic_idle: got rdy=%b vld=%b expected rdy=1 vld=0", bus.req_ready, bus.rsp_valid); end
   endtask

   task automatic test_stall();
      logic [31:0] bits; int pulses, span; logic pv;
      issue(16'hA5A5, 16'h5A5A);
      collect(10, 3, 1'b0, bits, pulses, span, pv);
      n_checks++; if (pulses !== 32) begin n_errors++; $display("FAIL stall_pulses: got %0d expected 32", pulses); end
      n_checks++; if (bits !== 32'h5A5A_A5A5) begin n_errors++; $display("FAIL stall_bits: got %h expected 5a5aa5a5", bits); end
      n_checks++; if (span !== 35) begin n_errors++; $display("FAIL stall_span: got %0d expected 35", span); end
      respond(bits[15:0] & bits[31:16], -1, 0);
      n_checks++; if (bus.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL stall_rsp_valid: got %b expected 1", bus.rsp_valid); end
      n_checks++; if (bus.rsp_result !== 16'h0000) begin n_errors++; $display("FAIL stall_result: got %h expected 0000", bus.rsp_result); end
      release_rsp();
   endtask

   task automatic test_gap();
      logic [31:0] bits; int pulses, span; logic pv;
      issue(16'h1234, 16'hFFFF);
      collect(-1, 0, 1'b0, bits, pulses, span, pv);
      respond(bits[15:0] & bits[31:16], 7, 5);
      n_checks++; if (bus.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL gap_rsp_valid: got %b expected 1", bus.rsp_valid); end
      n_checks++; if (bus.rsp_result !== 16'h1234) begin n_errors++; $display("FAIL gap_result: got %h expected 1234", bus.rsp_result); end
      n_checks++; if (bus.rsp_error !== 1'b0) begin n_errors++; $display("FAIL gap_error: got %b expected 0", bus.rsp_error); end
      release_rsp();
   endtask

   task automatic test_timeout();
      logic [31:0] bits; int pulses, span; logic pv; int n;
      issue(16'h1111, 16'h2222);
      collect(-1, 0, 1'b0, bits, pulses, span, pv);
      n = 1;
      while (link_rst !== 1'b1 && n < 100) begin
         @(negedge pc_clk);
         n++;
      end
      n_checks++; if (n !== 64) begin n_errors++; $display("FAIL timeout_latency: got %0d expected 64", n); end
      @(negedge pc_clk);
      n_checks++; if (link_rst !== 1'b1) begin n_errors++; $display("FAIL timeout_link_2nd: got %b expected 1", link_rst); end
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL timeout_early_valid: got %b expected 0", bus.rsp_valid); end
      @(negedge pc_clk);
      n_checks++; if (link_rst !== 1'b0) begin n_errors++; $display("FAIL timeout_link_end: got %b expected 0", link_rst); end
      n_checks++; if (bus.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL timeout_rsp_valid: got %b expected 1", bus.rsp_valid); end
      n_checks++; if (bus.rsp_error !== 1'b1) begin n_errors++; $display("FAIL timeout_error: got %b expected 1", bus.rsp_error); end
      n_checks++; if (bus.rsp_result !== 16'h0) begin n_errors++; $display("FAIL timeout_result: got %h expected 0000", bus.rsp_result); end
      release_rsp();
   endtask

   task automatic test_reset_mid();
      logic [31:0] bits; int pulses, span, cyc; logic pv;
      issue(16'hAAAA, 16'h5555);
      pulses = 0;
      cyc    = 0;
      while (pulses < 20 && cyc < 100) begin
         @(negedge pc_clk);
         cyc++;
         if (pc_valid === 1'b1) pulses++;
      end
      pc_rst = 1'b1;
      #1;
      n_checks++; if (pc_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_pc_valid: got %b expected 0", pc_valid); end
      n_checks++; if (link_rst !== 1'b1) begin n_errors++; $display("FAIL midrst_link_rst: got %b expected 1", link_rst); end
      n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL midrst_req_ready: got %b expected 1", bus.req_ready); end
      @(negedge pc_clk);
      @(negedge pc_clk);
      pc_rst = 1'b0;
      @(negedge pc_clk);
      n_checks++; if (bus.rsp_valid !== 1'b0 || pc_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_quiet: got vld=%b pcv=%b expected 0 0", bus.rsp_valid, pc_valid); end
      n_checks++; if (link_rst !== 1'b0) begin n_errors++; $display("FAIL midrst_link_release: got %b expected 0", link_rst); end
      issue(16'h00FF, 16'h0F0F);
      collect(-1, 0, 1'b0, bits, pulses, span, pv);
      n_checks++; if (bits !== 32'h0F0F_00FF) begin n_errors++; $display("FAIL midrst_bits: got %h expected 0f0f00ff", bits); end
      respond(bits[15:0] & bits[31:16], -1, 0);
      n_checks++; if (bus.rsp_result !== 16'h000F || bus.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL midrst_result: got %h vld=%b expected 000f vld=1", bus.rsp_result, bus.rsp_valid); end
      release_rsp();
   endtask

   task automatic test_hold();
      logic [31:0] bits; int pulses, span; logic pv;
      issue(16'hC3C3, 16'h0FF0);
      collect(-1, 0, 1'b0, bits, pulses, span, pv);
      respond(bits[15:0] & bits[31:16], -1, 0);
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'h03C0 || bus.req_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_cycle%0d: got vld=%b res=%h rdy=%b expected vld=1 res=03c0 rdy=0",
                     i, bus.rsp_valid, bus.rsp_result, bus.req_ready);
         end
         @(negedge pc_clk);
      end
      release_rsp();
      n_checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL hold_idle: got rdy=%b vld=%b expected rdy=1 vld=0", bus.req_ready, bus.rsp_valid); end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_gap();
      test_timeout();
      test_reset_mid();
      test_hold();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/okand_host.md
OKAND_HOST -- requirements
Module: okand_host

Interface
REQ-001 SHALL have parameter OP_W, default 16, operand and result width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum idle cycles waiting for the response before abort.
REQ-003 pc_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 pc_rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 op_a  input  OP_W  first operand, sent first.
REQ-008 op_b  input  OP_W  second operand.
REQ-009 tx_stall  input  1  when high, the serial link is paused this cycle.
REQ-010 pc_data  output  1  serial operand bit to the responder.
REQ-011 pc_valid  output  1  pc_data valid this cycle.
REQ-012 link_rst  output  1  synchronous reset pulse to the responder.
REQ-013 fpga_data  input  1  serial result bit from the responder.
REQ-014 fpga_valid  input  1  fpga_data valid this cycle.
REQ-015 rsp_valid  output  1  result available.
REQ-016 rsp_ready  input  1  consumer takes the result.
REQ-017 rsp_result  output  OP_W  assembled result.
REQ-018 rsp_error  output  1  response timed out; rsp_result is 0.

Function
REQ-019 SHALL implement states IDLE, SEND, WAIT, RECV, DONE, ABORT.
REQ-020 req_ready SHALL be 1 only in IDLE; req_valid&&req_ready latches {op_b,op_a} into a 2*OP_W shift register and enters SEND.
REQ-021 In SEND, each non-stalled cycle SHALL drive registered pc_valid=1 and one bit: op_a bit 0..OP_W-1, then op_b bit 0..OP_W-1, LSB first.
REQ-022 When tx_stall=1, pc_valid SHALL be 0 in the following cycle, with the bit index held; pc_data is don't-care.
REQ-023 After bit 2*OP_W-1 is driven, the block SHALL enter WAIT with pc_valid=0 next cycle; one request is outstanding at a time.
REQ-024 In WAIT/RECV, each cycle with fpga_valid=1 SHALL store fpga_data at result bit index rx_idx, LSB first, and increment rx_idx; WAIT->RECV on the first valid bit.
REQ-025 fpga_valid gaps SHALL be tolerated and SHALL NOT reset rx_idx.
REQ-026 On capture of bit OP_W-1, the block SHALL enter DONE next cycle with rsp_valid=1 and rsp_error=0.
REQ-027 fpga_valid outside WAIT/RECV SHALL be ignored.
REQ-028 Timeout counter: cleared on entering WAIT and on each captured bit; when it reaches TIMEOUT, the block SHALL go to ABORT.
REQ-029 ABORT SHALL assert link_rst for exactly 2 cycles, then enter DONE with rsp_error=1 and rsp_result=0.
REQ-030 DONE SHALL hold rsp_valid, rsp_result and rsp_error stable until rsp_ready=1, then return to IDLE next cycle.
REQ-031 req_ready and rsp_valid SHALL never both be 1.

Reset
REQ-032 pc_rst SHALL asynchronously force IDLE and clear pc_data, pc_valid, rsp_valid, rsp_result, rsp_error, the counters and the shift register.
REQ-033 pc_rst SHALL force link_rst=1 while asserted; link_rst deasserts on the first pc_clk edge after release.
REQ-034 Reset mid-SEND or mid-RECV SHALL discard the transaction with no rsp_valid.

Structure
REQ-035 Package okand_pkg SHALL hold OP_W default, TIMEOUT default and the state enum type.
REQ-036 Sub-module okand_timeout SHALL provide the timeout counter with clear/expire ports.

Verification
REQ-037 op_a=0xFFFF, op_b=0x0F0F, bench responder model -> exactly 32 pc_valid pulses, LSB first; rsp_result=0x0F0F, rsp_error=0.
REQ-038 op_a=0xA5A5, op_b=0x5A5A, tx_stall high for 3 cycles at bit 10 -> pc_valid low for 3 cycles, bit order intact; rsp_result=0x0000.
REQ-039 Response delivered with a 5-cycle fpga_valid gap after bit 7, operands 0x1234 & 0xFFFF -> rsp_result=0x1234.
REQ-040 Responder silent after SEND -> after 64 idle cycles link_rst is high for 2 cycles; then rsp_valid=1, rsp_error=1, rsp_result=0.
REQ-041 pc_rst asserted at bit 20 of SEND -> outputs cleared immediately; next request 0x00FF & 0x0F0F -> rsp_result=0x000F.
REQ-042 rsp_ready held low 10 cycles in DONE -> rsp_valid and rsp_result stable, req_ready=0; IDLE one cycle after rsp_ready=1.
